reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- General-purpose register file for the MIPS CPU: 32 registers, 32 bits each.
- It is the consumer end of the destination-register path. It accepts the 5-bit write address chosen by the RegDst selection (rt, rd or 31) together with the write-back data, and commits the write on the clock edge.
- It supplies two combinational read ports (rs, rt) to decode/ALU operand selection.
- Register $0 is hardwired to zero. A write-to-read bypass lets the same cycle's write-back data reach the readers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- BYPASS, 1, 1 = a read address matching an active write returns wdata in the same cycle; 0 = the read returns the stored (old) value until the edge.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  RegWrite from control; commit wdata to waddr on this edge.
- waddr  in  ADDR_W  destination register from the RegDst selection (rt, rd or 31).
- wdata  in  DATA_W  write-back data (ALU result, memory data, or PC+4 for link).
- raddr1  in  ADDR_W  rs read address.
- raddr2  in  ADDR_W  rt read address.
- rdata1  out  DATA_W  rs read data, combinational.
- rdata2  out  DATA_W  rt read data, combinational.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 2**ADDR_W entries to 0, independent of clk.
  - While rst_n is low, rdata1 and rdata2 are 0 for every address, and any write is ignored.
  - Deassertion is taken synchronously by the first rising edge after rst_n is high.
- Write:
  - On a rising edge with rst_n=1, we=1 and waddr!=0: mem[waddr] <= wdata. Write latency is 1 edge.
  - we=1 with waddr=0 has no effect; $0 stays 0 always.
  - we=0 leaves every entry unchanged, whatever is on waddr and wdata.
- Read:
  - Purely combinational from raddrN to rdataN; zero cycle latency.
  - raddrN=0 always returns 0. This rule has priority over bypass.
  - BYPASS=1, with we=1, waddr==raddrN and raddrN!=0: rdataN = wdata in that same cycle.
  - BYPASS=0, same condition: rdataN = old mem[raddrN] until the edge, then the new value.
- Both read ports are independent. raddr1==raddr2 is legal and both ports return identical data. Both may bypass simultaneously.
- Reset asserted mid-cycle while we=1: the write is lost, the entry reads 0, and the bypass is suppressed (rdata gated to 0 while rst_n low).
- Address 31 (link register) has no special treatment here; the jal-path value arrives via wdata.
- No X on outputs after reset for any address. An X on we while rst_n is high is a bench error, not a defined behaviour.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults.
  - Constants REG_ZERO=5'd0, REG_RA=5'd31.
  - RegDst encodings REGDST_RT=2'd0, REGDST_RD=2'd1, REGDST_RA=2'd2.
- One natural sub-module: reg_read_port (zero check + bypass compare + storage select), instantiated twice.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rdata = 32'h0000_0000.
- we=1, waddr=5'd8, wdata=32'hDEAD_BEEF; one edge later raddr1=8 -> rdata1 = 32'hDEAD_BEEF. Then write waddr=0, wdata=32'hFFFF_FFFF; raddr2=0 -> rdata2 = 0.
- BYPASS=1: mem[9]=32'h1; in the same cycle we=1, waddr=9, wdata=32'h2, raddr1=raddr2=9 -> both ports = 32'h2 before the edge and after it.
- BYPASS=0, same stimulus -> both ports = 32'h1 before the edge, 32'h2 after it.
- Link write: waddr=31 (REG_RA), wdata=32'h0040_0008, we=1 -> raddr2=31 reads 32'h0040_0008. With we=0, waddr=31, wdata=32'h0 for one edge -> still 32'h0040_0008.
- Load regs 1..31 with value = index. Pulse rst_n low mid-cycle while a write to reg 5 is active -> outputs go to 0 immediately (asynchronously). After release, all regs read 0 and reg 5 was not written.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file and its neighbours.
//   REG_DATA_W / REG_ADDR_W : default register width and address width
//   REG_ZERO / REG_RA       : hardwired-zero register and link register
//   REGDST_*                : RegDst mux encodings (rt, rd or 31)
package cpu_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2
    } regdst_e;

endpackage

// File: rtl/reg_file_wb_if.sv
// Register-file bus: one write port plus two combinational read ports.
//   we/waddr/wdata   : write-back request (committed on the clock edge)
//   raddr1/rdata1    : rs read port
//   raddr2/rdata2    : rt read port
// Handshake: there is no valid/ready pair; we is a per-cycle qualifier
// sampled on the rising edge, and read data is valid in the same cycle as
// its address.
// master = CPU side (drives addresses/data), slave = register file.
interface reg_file_wb_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_read_port.sv
// One combinational read port of the register file.
//   rst_n  : while low the port returns 0 (also suppresses bypass)
//   raddr  : read address; address 0 always returns 0
//   we/waddr/wdata : current write request, used for same-cycle bypass
//   mem    : storage array
//   rdata  : read data, zero latency
module reg_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem [1<<ADDR_W],
    output logic [DATA_W-1:0] rdata
);
    logic is_zero;
    logic hit;

    assign is_zero = (raddr == ADDR_W'(REG_ZERO));
    // Bypass only makes sense for a write that will actually land.
    assign hit     = (BYPASS != 0) && we && (waddr == raddr);

    // Priority: reset gate, then $0, then bypass, then storage.
    always_comb begin
        rdata = '0;
        if (!rst_n || is_zero) begin
            rdata = '0;
        end else if (hit) begin
            rdata = wdata;
        end else begin
            rdata = mem[raddr];
        end
    end
endmodule

// File: rtl/reg_file_wb.sv
// MIPS general-purpose register file: 2**ADDR_W x DATA_W, $0 hardwired 0.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every entry
//   bus   : reg_file_wb_if slave (write port + two read ports)
// BYPASS=1 forwards a same-cycle write to matching readers; BYPASS=0
// returns the stored value until the edge.
module reg_file_wb
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_wb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;

    // Writes to $0 are dropped so entry 0 stays at its reset value.
    assign wr_en = bus.we && (bus.waddr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .rst_n (rst_n),
        .raddr (bus.raddr1),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .mem   (mem),
        .rdata (bus.rdata1)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .rst_n (rst_n),
        .raddr (bus.raddr2),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .mem   (mem),
        .rdata (bus.rdata2)
    );
endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: one instance with bypass, one without, both driven
// by the same stimulus.
module tb_reg_file_wb;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_b.we = we;     assign bus_n.we = we;
    assign bus_b.waddr = waddr;   assign bus_n.waddr = waddr;
    assign bus_b.wdata = wdata;   assign bus_n.wdata = wdata;
    assign bus_b.raddr1 = raddr1; assign bus_n.raddr1 = raddr1;
    assign bus_b.raddr2 = raddr2; assign bus_n.raddr2 = raddr2;

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );
    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .bus(bus_n.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // e1b/e2b: expected on bypass instance; e1n/e2n: on non-bypass instance
    task automatic check4(input string tag, input logic [31:0] e1b, input logic [31:0] e2b,
                          input logic [31:0] e1n, input logic [31:0] e2n);
        check({tag, "_b_r1"}, bus_b.rdata1, e1b);
        check({tag, "_b_r2"}, bus_b.rdata2, e2b);
        check({tag, "_n_r1"}, bus_n.rdata1, e1n);
        check({tag, "_n_r2"}, bus_n.rdata2, e2n);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check4(tag, 32'h0, 32'h0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd8; raddr2 = 5'd31;
        #2;
        check4("in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        // write attempted during reset is ignored and not bypassed
        we = 1'b1; waddr = 5'd8; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check4("rst_wr", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        read_all_zero("post_rst");

        // basic write / read
        write_reg(5'd8, 32'hDEAD_BEEF);
        @(negedge clk);
        raddr1 = 5'd8; raddr2 = 5'd8;
        #1;
        check4("wr8", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // write to $0 is dropped, including the bypass path
        @(negedge clk);
        we = 1'b1; waddr = REG_ZERO; wdata = 32'hFFFF_FFFF; raddr1 = 5'd8; raddr2 = REG_ZERO;
        #1;
        check4("wr0_pre", 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check4("wr0_post", 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0);

        // bypass vs. no bypass on reg 9
        write_reg(5'd9, 32'h1);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h2; raddr1 = 5'd9; raddr2 = 5'd9;
        #1;
        check4("byp_pre", 32'h2, 32'h2, 32'h1, 32'h1);
        @(posedge clk); #1;
        check4("byp_post", 32'h2, 32'h2, 32'h2, 32'h2);
        we = 1'b0;

        // link register write, then an idle edge with waddr=31
        write_reg(REG_RA, 32'h0040_0008);
        @(negedge clk);
        raddr2 = REG_RA; raddr1 = 5'd8;
        #1;
        check4("link", 32'hDEAD_BEEF, 32'h0040_0008, 32'hDEAD_BEEF, 32'h0040_0008);
        @(negedge clk);
        we = 1'b0; waddr = REG_RA; wdata = 32'h0;
        @(posedge clk); #1;
        check4("link_we0", 32'hDEAD_BEEF, 32'h0040_0008, 32'hDEAD_BEEF, 32'h0040_0008);

        // load regs 1..31 with their index and read back through the queue
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i));
            exp_q.push_back(32'(i));
        end
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            #1;
            check("load_b_r1", bus_b.rdata1, e);
            check("load_n_r1", bus_n.rdata1, e);
            check("load_b_r2", bus_b.rdata2, 32'(32 - i));
        end

        // reset pulse in the middle of a write to reg 5
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_5555; raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        check4("mid_pre", 32'hAAAA_5555, 32'h6, 32'h5, 32'h6);
        #1;
        rst_n = 1'b0;
        #1;
        check4("mid_async", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check4("mid_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check4("reg5_lost", 32'h0, 32'h0, 32'h0, 32'h0);
        read_all_zero("after_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
